// File: rtl/nibble_serial_subtractor_pkg.sv
// nibble_serial_subtractor_pkg: nibble width and FSM state encoding shared by the serial subtractor files
package nibble_serial_subtractor_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: start/done bus; master drives start,a,b,bin and receives busy,done,diff,bout,ovf
interface nibble_serial_subtractor_if #(parameter int WIDTH = 16);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
  logic ovf;
  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/nibble_serial_subtractor_sub4bit.sv
// nibble_serial_subtractor_sub4bit: combinational a-b-bin over one nibble via four rippled full subtractors; ports a,b,bin in, diff,bout out
module nibble_serial_subtractor_sub4bit
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);
  logic [NIBBLE_W:0] c;
  assign c[0] = bin;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_cell
    assign diff[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end
  assign bout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: diff = a - b - bin one nibble per clock, LSB first; ports clk, reset (async high), bus (slave modport)
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset,
  nibble_serial_subtractor_if.slave bus
);
  localparam int N = WIDTH / NIBBLE_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, work, work_nx;
  logic brw;
  logic [NIBBLE_W-1:0] na, nb, nd;
  logic nbo;
  assign na = a_r[NIBBLE_W*cnt +: NIBBLE_W];
  assign nb = b_r[NIBBLE_W*cnt +: NIBBLE_W];
  nibble_serial_subtractor_sub4bit u_slice (.a(na), .b(nb), .bin(brw), .diff(nd), .bout(nbo));
  always_comb begin
    work_nx = work;
    work_nx[NIBBLE_W*cnt +: NIBBLE_W] = nd;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      brw <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r <= bus.a;
            b_r <= bus.b;
            brw <= bus.bin;
            cnt <= '0;
            bus.busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work <= work_nx;
          brw <= nbo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bus.diff <= work_nx;
            bus.bout <= nbo;
            bus.ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (work_nx[WIDTH-1] != a_r[WIDTH-1]);
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed and random checks of the 16-bit and 4-bit serial subtractors
module tb_nibble_serial_subtractor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  nibble_serial_subtractor_if #(.WIDTH(16)) i16 ();
  nibble_serial_subtractor_if #(.WIDTH(4)) i4 ();
  nibble_serial_subtractor #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(i16));
  nibble_serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(i4));
  always #5 clk = ~clk;

  task automatic do_op(input logic [15:0] a, b, input logic bin, output logic [15:0] d,
                       output logic bo, ov, output int lat, pw);
    i16.a = a;
    i16.b = b;
    i16.bin = bin;
    i16.start = 1'b1;
    @(posedge clk);
    #1 i16.start = 1'b0;
    lat = 1;
    while (i16.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    d = i16.diff;
    bo = i16.bout;
    ov = i16.ovf;
    pw = 0;
    while (i16.done === 1'b1 && pw < 5) begin
      pw++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op4(input logic [3:0] a, b, input logic bin, output logic [3:0] d,
                        output logic bo, output int lat, pw);
    i4.a = a;
    i4.b = b;
    i4.bin = bin;
    i4.start = 1'b1;
    @(posedge clk);
    #1 i4.start = 1'b0;
    lat = 1;
    while (i4.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    d = i4.diff;
    bo = i4.bout;
    pw = 0;
    while (i4.done === 1'b1 && pw < 5) begin
      pw++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    total++;
    if ({i16.busy, i16.done, i16.bout, i16.ovf, i16.diff} !== 20'h0) begin
      bad++;
      $display("FAIL reset_in: got busy=%b done=%b diff=%h bout=%b ovf=%b want all 0",
               i16.busy, i16.done, i16.diff, i16.bout, i16.ovf);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({i16.busy, i16.done, i16.diff} !== 18'h0 || {i4.busy, i4.done, i4.diff} !== 6'h0) begin
      bad++;
      $display("FAIL reset_out: got busy=%b done=%b diff=%h busy4=%b diff4=%h want 0",
               i16.busy, i16.done, i16.diff, i4.busy, i4.diff);
    end
  endtask

  task automatic test_basic;
    logic [15:0] d;
    logic bo, ov;
    int lat, pw;
    logic [15:0] ta[3] = '{16'h1234, 16'h0000, 16'h8000};
    logic [15:0] tb[3] = '{16'h0234, 16'h0001, 16'h0001};
    logic [15:0] td[3] = '{16'h1000, 16'hFFFF, 16'h7FFF};
    logic tbo[3] = '{1'b0, 1'b1, 1'b0};
    logic tov[3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_op(ta[k], tb[k], 1'b0, d, bo, ov, lat, pw);
      total++;
      if (d !== td[k] || bo !== tbo[k] || ov !== tov[k]) begin
        bad++;
        $display("FAIL basic%0d: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 k, d, bo, ov, td[k], tbo[k], tov[k]);
      end
      total++;
      if (lat !== 5 || pw !== 1) begin
        bad++;
        $display("FAIL basic%0d_timing: got lat=%0d pw=%0d want lat=5 pw=1", k, lat, pw);
      end
    end
  endtask

  task automatic test_width4;
    logic [3:0] d;
    logic bo;
    int lat, pw;
    do_op4(4'hB, 4'h4, 1'b0, d, bo, lat, pw);
    total++;
    if (d !== 4'h7 || bo !== 1'b0 || lat !== 2 || pw !== 1) begin
      bad++;
      $display("FAIL w4_a: got diff=%h bout=%b lat=%0d pw=%0d want 7 0 2 1", d, bo, lat, pw);
    end
    do_op4(4'h7, 4'hD, 1'b1, d, bo, lat, pw);
    total++;
    if (d !== 4'h9 || bo !== 1'b1 || lat !== 2 || pw !== 1) begin
      bad++;
      $display("FAIL w4_b: got diff=%h bout=%b lat=%0d pw=%0d want 9 1 2 1", d, bo, lat, pw);
    end
  endtask

  task automatic test_ignore_start;
    int n = 0;
    logic [15:0] d = '0;
    logic bo = 1'b0;
    i16.a = 16'h0005;
    i16.b = 16'h0005;
    i16.bin = 1'b1;
    i16.start = 1'b1;
    @(posedge clk);
    #1 i16.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i16.start = 1'b1;
    i16.a = 16'h1111;
    i16.b = 16'h0000;
    i16.bin = 1'b0;
    @(posedge clk);
    #1 i16.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (i16.done === 1'b1) begin
        n++;
        d = i16.diff;
        bo = i16.bout;
      end
    end
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL ignore_count: got %0d done pulses want 1", n);
    end
    total++;
    if (d !== 16'hFFFF || bo !== 1'b1 || i16.diff !== 16'hFFFF) begin
      bad++;
      $display("FAIL ignore_result: got diff=%h bout=%b held=%h want FFFF 1 FFFF", d, bo, i16.diff);
    end
  endtask

  task automatic test_reset_abort;
    int n = 0;
    logic [15:0] d;
    logic bo, ov;
    int lat, pw;
    i16.a = 16'h1234;
    i16.b = 16'h0001;
    i16.bin = 1'b0;
    i16.start = 1'b1;
    @(posedge clk);
    #1 i16.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if (i16.busy !== 1'b0 || i16.done !== 1'b0 || i16.diff !== 16'h0 || i16.bout !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b done=%b diff=%h bout=%b want 0 0 0000 0",
               i16.busy, i16.done, i16.diff, i16.bout);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (i16.done === 1'b1) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL abort_nodone: got %0d done pulses want 0", n);
    end
    do_op(16'h0010, 16'h0001, 1'b0, d, bo, ov, lat, pw);
    total++;
    if (d !== 16'h000F || bo !== 1'b0 || lat !== 5 || pw !== 1) begin
      bad++;
      $display("FAIL abort_next: got diff=%h bout=%b lat=%0d pw=%0d want 000F 0 5 1", d, bo, lat, pw);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] oa[3] = '{16'hFFFF, 16'h1000, 16'h7FFF};
    logic [15:0] ob[3] = '{16'h0001, 16'h2000, 16'hFFFF};
    logic obin[3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] m;
    int k = 0;
    int e = 0;
    int last = -1;
    i16.a = oa[0];
    i16.b = ob[0];
    i16.bin = obin[0];
    i16.start = 1'b1;
    while (k < 3 && e < 60) begin
      @(posedge clk);
      #1 e++;
      if (i16.done === 1'b1) begin
        m = {1'b0, oa[k]} - {1'b0, ob[k]} - {16'h0, obin[k]};
        total++;
        if (i16.diff !== m[15:0] || i16.bout !== m[16]) begin
          bad++;
          $display("FAIL b2b%0d: got diff=%h bout=%b want diff=%h bout=%b", k, i16.diff, i16.bout, m[15:0], m[16]);
        end
        if (k > 0) begin
          total++;
          if (e - last !== 6) begin
            bad++;
            $display("FAIL b2b%0d_period: got %0d want 6", k, e - last);
          end
        end
        last = e;
        k++;
        if (k < 3) begin
          i16.a = oa[k];
          i16.b = ob[k];
          i16.bin = obin[k];
        end else i16.start = 1'b0;
      end
    end
    i16.start = 1'b0;
    total++;
    if (k !== 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d completions want 3", k);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [15:0] a, b, d;
    logic bin, bo, ov;
    logic [16:0] m;
    int lat, pw;
    for (int k = 0; k < 200; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom_range(0, 1));
      m = {1'b0, a} - {1'b0, b} - {16'h0, bin};
      do_op(a, b, bin, d, bo, ov, lat, pw);
      total++;
      if (d !== m[15:0] || bo !== m[16] || ov !== ((a[15] != b[15]) && (m[15] != a[15])) || lat !== 5 || pw !== 1) begin
        bad++;
        $display("FAIL rand%0d: %h-%h-%b got diff=%h bout=%b ovf=%b lat=%0d pw=%0d want diff=%h bout=%b",
                 k, a, b, bin, d, bo, ov, lat, pw, m[15:0], m[16]);
      end
    end
  endtask

  initial begin
    i16.start = 1'b0;
    i16.a = '0;
    i16.b = '0;
    i16.bin = 1'b0;
    i4.start = 1'b0;
    i4.a = '0;
    i4.b = '0;
    i4.bin = 1'b0;
    test_reset;
    test_basic;
    test_width4;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
